// File: rtl/morse_pkg.sv
// Shared types and unit constants for the Morse tone sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    EGAP = 2'd2,
    CGAP = 2'd3
  } state_t;

  localparam logic [2:0] DOT_UNITS  = 3'd1;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] EGAP_UNITS = 3'd1;
  localparam logic [2:0] CGAP_UNITS = 3'd3;
  localparam logic [2:0] WGAP_UNITS = 3'd7;
  localparam logic [2:0] MAX_LEN    = 3'd6;

  // Tone length in units for one element (1 = dash).
  function automatic logic [2:0] elem_units(input logic dash);
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

  // Closing gap length in units; a word boundary stretches it.
  function automatic logic [2:0] gap_units(input logic word_end);
    return word_end ? WGAP_UNITS : CGAP_UNITS;
  endfunction

endpackage

// File: rtl/morse_tone_sequencer_if.sv
// Symbol handshake channel into the tone sequencer.
interface morse_tone_sequencer_if;
  logic        sym_valid;
  logic        sym_ready;
  logic [2:0]  sym_len;
  logic [5:0]  sym_pat;
  logic        sym_word_end;
  logic [31:0] tone_div;

  modport master (
    output sym_valid, sym_len, sym_pat, sym_word_end, tone_div,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_len, sym_pat, sym_word_end, tone_div,
    output sym_ready
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Unit timer: a cycle prescaler that wraps every UNIT_CYCLES cycles and a
// 3-bit unit countdown. expire is high on the last cycle of the loaded span.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] load,
  output logic       expire
);

  localparam logic [31:0] PRE_LAST = UNIT_CYCLES - 1;

  logic [31:0] pre_cnt;
  logic [2:0]  units;
  logic        running;
  logic        pre_wrap;

  assign pre_wrap = (pre_cnt == PRE_LAST);
  assign expire   = running && pre_wrap && (units == 3'd1);

  // Prescaler and countdown; start restarts both, stop/reset idles the timer.
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      pre_cnt <= '0;
      units   <= '0;
      running <= 1'b0;
    end else if (start) begin
      pre_cnt <= '0;
      units   <= load;
      running <= (load != 3'd0);
    end else if (running) begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        units   <= units - 3'd1;
        if (units == 3'd1) running <= 1'b0;
      end else begin
        pre_cnt <= pre_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/morse_tone_sequencer.sv
// Morse tone sequencer: plays one symbol (up to six dots/dashes) as a gated
// piezo tone, followed by a character or word gap, then pulses done.
module morse_tone_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6000000,
  parameter logic [31:0] DEFAULT_DIV = 32'd35714
) (
  input  logic                          clk,
  input  logic                          rst,
  morse_tone_sequencer_if.slave         sym,
  input  logic                          abort,
  output logic                          tone_en,
  output logic [31:0]                   freq_div,
  output logic                          busy,
  output logic                          done
);

  state_t      state_q, state_d;
  logic [5:0]  pat_q, pat_d;
  logic [2:0]  rem_q, rem_d;
  logic        word_q, word_d;
  logic [31:0] div_q, div_d;
  logic        tone_en_d;
  logic        accept;
  logic [2:0]  len_c;
  logic        tmr_start;
  logic [2:0]  tmr_load;
  logic        tmr_expire;

  // Ready is also held off while reset is asserted so nothing slips in.
  assign sym.sym_ready = (state_q == IDLE) && !abort && !rst;
  assign accept        = sym.sym_valid && sym.sym_ready;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == CGAP) && tmr_expire && !abort;
  assign freq_div      = div_q;

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (tmr_start),
    .stop   (abort),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  // Next state, latched fields and timer reloads; pattern shifts out LSB first.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    word_d    = word_q;
    div_d     = div_q;
    tmr_start = 1'b0;
    tmr_load  = 3'd0;
    len_c     = (sym.sym_len > MAX_LEN) ? MAX_LEN : sym.sym_len;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_d     = sym.sym_pat;
          word_d    = sym.sym_word_end;
          div_d     = sym.tone_div;
          rem_d     = len_c;
          tmr_start = 1'b1;
          if (len_c != 3'd0) begin
            state_d  = TONE;
            tmr_load = elem_units(sym.sym_pat[0]);
          end else begin
            state_d  = CGAP;
            tmr_load = gap_units(sym.sym_word_end);
          end
        end
      end
      TONE: begin
        if (tmr_expire) begin
          rem_d     = rem_q - 3'd1;
          pat_d     = pat_q >> 1;
          tmr_start = 1'b1;
          if (rem_q == 3'd1) begin
            state_d  = CGAP;
            tmr_load = gap_units(word_q);
          end else begin
            state_d  = EGAP;
            tmr_load = EGAP_UNITS;
          end
        end
      end
      EGAP: begin
        if (tmr_expire) begin
          state_d   = TONE;
          tmr_start = 1'b1;
          tmr_load  = elem_units(pat_q[0]);
        end
      end
      CGAP: begin
        if (tmr_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the symbol; the divider keeps its last value.
    if (abort) begin
      state_d   = IDLE;
      pat_d     = '0;
      rem_d     = '0;
      word_d    = 1'b0;
      tmr_start = 1'b0;
    end

    // A zero divider mutes the symbol without touching its timing.
    tone_en_d = (state_d == TONE) && (div_d != 32'd0);
  end

  // State and latched-field registers; tone_en is registered off next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      word_q  <= 1'b0;
      div_q   <= DEFAULT_DIV;
      tone_en <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      div_q   <= div_d;
      tone_en <= tone_en_d;
    end
  end

endmodule

// File: doc/morse_tone_sequencer.md
MORSE_TONE_SEQUENCER -- requirements
Module: morse_tone_sequencer

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 6000000, giving the clock cycles per Morse unit (120 ms at 50 MHz); legal range is at least 1.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 35714, giving the reset value of freq_div (700 Hz at 50 MHz).
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sym_valid  input  1  a symbol is offered.
REQ-007 sym_ready  output  1  the block can accept a symbol.
REQ-008 sym_len  input  3  element count, 0..6.
REQ-009 sym_pat  input  6  element pattern: bit0 is sent first; 1=dash, 0=dot.
REQ-010 sym_word_end  input  1  a word gap follows this symbol.
REQ-011 tone_div  input  32  pitch divider, sampled at accept.
REQ-012 abort  input  1  synchronous cancel.
REQ-013 tone_en  output  1  drives the downstream piezo enable.
REQ-014 freq_div  output  32  drives the downstream piezo divider.
REQ-015 busy  output  1  the block is not in IDLE.
REQ-016 done  output  1  one-cycle pulse when a symbol completes.

Function
REQ-017 The FSM SHALL have the states IDLE, TONE, EGAP (inter-element gap) and CGAP (final gap).
REQ-018 sym_ready SHALL be 1 only in IDLE and only when abort=0; a symbol SHALL be accepted when sym_valid and sym_ready are both 1.
REQ-019 On accept, the block SHALL latch sym_pat, sym_word_end and tone_div, and SHALL clamp sym_len>6 to 6.
REQ-020 Accept with len>=1 SHALL enter TONE on the next cycle, with tone_en=1 from that cycle (1-cycle latency).
REQ-021 TONE SHALL last exactly 1*UNIT_CYCLES cycles for a dot and 3*UNIT_CYCLES cycles for a dash.
REQ-022 After an element that is not the last, the FSM SHALL enter EGAP for exactly 1*UNIT_CYCLES cycles with tone_en=0, then TONE for the next element.
REQ-023 After the last element, the FSM SHALL enter CGAP for 3*UNIT_CYCLES cycles, or 7*UNIT_CYCLES cycles if word_end was latched.
REQ-024 Accept with len=0 SHALL go directly to CGAP (pure gap of 3 or 7 units); tone_en SHALL stay 0 throughout.
REQ-025 On the last cycle of CGAP, done SHALL pulse for one cycle and the FSM SHALL return to IDLE on the next cycle.
REQ-026 The minimum low time of tone_en between back-to-back symbols SHALL be the CGAP length plus 1 cycle.
REQ-027 tone_en SHALL be a registered output that is 1 only in TONE.
REQ-028 freq_div SHALL hold the latched tone_div value; while tone_en=0, freq_div is don't-care downstream but SHALL keep its last value.
REQ-029 A latched tone_div of 0 SHALL force tone_en to 0 for the whole symbol, while all timing is unchanged.
REQ-030 abort=1 in any state SHALL, on the next cycle, give state IDLE, tone_en=0 and done=0, and discard the symbol.
REQ-031 abort takes priority over an accept in the same cycle: the offered symbol SHALL NOT be accepted.
REQ-032 The unit cycle counter SHALL count 0..UNIT_CYCLES-1 and wrap, without overflow at 32 bits.
REQ-033 The unit countdown SHALL be 3 bits wide (maximum value 7).
REQ-034 busy SHALL equal (state != IDLE).

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL go to state IDLE, with tone_en=0, done=0, busy=0 and sym_ready=0, and freq_div=DEFAULT_DIV.
REQ-036 Both counters and all latched fields SHALL be cleared by reset.
REQ-037 sym_ready SHALL go to 1 on the first cycle after rst deasserts.
REQ-038 Reset mid-tone SHALL drop tone_en on the same edge, and no done pulse SHALL follow.

Structure
REQ-039 Package morse_pkg SHALL hold the state enum and the constants DOT_UNITS=1, DASH_UNITS=3, EGAP_UNITS=1, CGAP_UNITS=3, WGAP_UNITS=7 and MAX_LEN=6.
REQ-040 A sub-module, morse_unit_timer, SHALL hold the cycle prescaler and the unit countdown; it takes a load value and start, and produces a one-cycle expire pulse.

Verification (UNIT_CYCLES=4)
REQ-041 The bench SHALL cover: 'A' (len=2, pat=6'b000010, word_end=0) -> tone_en high 4 cycles, low 4, high 12, low 12, done on the 32nd cycle after accept.
REQ-042 The bench SHALL cover: 'E' (len=1, pat=0, word_end=1) -> tone_en high 4 cycles, low 28, then one done pulse.
REQ-043 The bench SHALL cover: len=0 with word_end=1 -> tone_en never high, done 28 cycles after accept; then len=7 -> treated as 6 elements.
REQ-044 The bench SHALL cover: back-to-back 'T' 'T' with sym_valid held high -> tone_en low for exactly 13 cycles between the dashes, and sym_ready high for 1 cycle.
REQ-045 The bench SHALL cover: abort in cycle 5 of a dash -> tone_en=0 and sym_ready=1 on the next cycle, no done pulse; abort together with sym_valid in IDLE -> no accept.
REQ-046 The bench SHALL cover: rst during EGAP -> all outputs at reset values on the next edge; tone_div=0 symbol -> tone_en stays 0 while done timing is unchanged.
